// File: rtl/data_store_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_store_buffer_if : sram-like request/response bundle (core or bridge)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface data_store_buffer_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/data_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_store_buffer : posted-store FIFO between core data port and bridge    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  data_store_buffer_if.slave  cpu,
  data_store_buffer_if.master mem,
  output logic                buf_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WREQ  = 3'd1;
  localparam logic [2:0] ST_WWAIT = 3'd2;
  localparam logic [2:0] ST_RREQ  = 3'd3;
  localparam logic [2:0] ST_RWAIT = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_st_dok;
  logic          r_ld_dok;
  logic          r_live;
  logic [31:0]   r_rdata;
  logic [31:0]   r_ld_addr;
  logic [1:0]    r_ld_size;

  logic [1:0]    r_fsize [DEPTH];
  logic [3:0]    r_fstrb [DEPTH];
  logic [31:0]   r_faddr [DEPTH];
  logic [31:0]   r_fdata [DEPTH];

  logic w_ld_busy;
  logic w_st_acc;
  logic w_ld_acc;
  logic w_pop;
  logic w_ld_done;

  // r_live holds off acceptance until the first edge after reset release
  assign w_ld_busy = (r_state == ST_RREQ) || (r_state == ST_RWAIT);
  assign w_st_acc  = r_live && cpu.req && cpu.wr && (r_count != C_FULL) && !w_ld_busy;
  assign w_ld_acc  = r_live && cpu.req && !cpu.wr && (r_state == ST_IDLE)
                     && (r_count == '0) && !r_st_dok;
  assign w_pop     = (r_state == ST_WWAIT) && mem.data_ok;
  assign w_ld_done = (r_state == ST_RWAIT) && mem.data_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = ST_WREQ;
        end else if (w_ld_acc) begin
          w_state_nxt = ST_RREQ;
        end
      end
      ST_WREQ:  if (mem.addr_ok) w_state_nxt = ST_WWAIT;
      ST_WWAIT: if (mem.data_ok) w_state_nxt = ST_IDLE;
      ST_RREQ:  if (mem.addr_ok) w_state_nxt = ST_RWAIT;
      ST_RWAIT: if (mem.data_ok) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.req   = 1'b0;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    case (r_state)
      ST_WREQ: begin
        mem.req   = 1'b1;
        mem.wr    = 1'b1;
        mem.size  = r_fsize[r_head];
        mem.wstrb = r_fstrb[r_head];
        mem.addr  = r_faddr[r_head];
        mem.wdata = r_fdata[r_head];
      end
      ST_RREQ: begin
        mem.req  = 1'b1;
        mem.size = r_ld_size;
        mem.addr = r_ld_addr;
      end
      default: ;
    endcase
    cpu.addr_ok = w_st_acc || w_ld_acc;
    cpu.data_ok = r_st_dok || r_ld_dok;
    cpu.rdata   = r_rdata;
    buf_empty   = (r_count == '0) && (r_state != ST_WREQ) && (r_state != ST_WWAIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_st_dok  <= 1'b0;
      r_ld_dok  <= 1'b0;
      r_live    <= 1'b0;
      r_rdata   <= '0;
      r_ld_addr <= '0;
      r_ld_size <= '0;
    end else begin
      r_live   <= 1'b1;
      r_st_dok <= w_st_acc;
      r_ld_dok <= w_ld_done;
      if (w_st_acc) r_tail <= r_tail + AW'(1);
      if (w_pop)    r_head <= r_head + AW'(1);
      case ({w_st_acc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ld_acc) begin
        r_ld_addr <= cpu.addr;
        r_ld_size <= cpu.size;
      end
      if (w_ld_done) r_rdata <= mem.rdata;
    end
  end

  // Entry contents need no reset; validity is tracked by head/count alone
  always_ff @(posedge clk) begin
    if (w_st_acc) begin
      r_fsize[r_tail] <= cpu.size;
      r_fstrb[r_tail] <= cpu.wstrb;
      r_faddr[r_tail] <= cpu.addr;
      r_fdata[r_tail] <= cpu.wdata;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_data_store_buffer.sv
`default_nettype none
// Scoreboard bench: random core traffic, bridge responder model, ordered response checks.
module tb_data_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic buf_empty;

  data_store_buffer_if cpu_bus ();
  data_store_buffer_if mem_bus ();

  data_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .cpu(cpu_bus), .mem(mem_bus), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_ld; int cyc; logic [31:0] rdata; } cpu_exp_t;
  typedef struct { logic wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] addr; logic [31:0] wdata; } bus_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  cpu_exp_t exp_cpu[$];
  bus_t     exp_bus[$];
  logic [31:0] ref_mem [bit [29:0]];
  logic [31:0] bus_mem [bit [29:0]];

  int   m_out, ld_exp_cyc, dly, wr_cnt;
  bit   ld_busy, st_pend, acc_now, exp_ok;
  bit   busy, was_busy, fired, snap_valid, same;
  bit   stall_addr = 0, stall_dok = 0;
  bus_t cur, snap, req_now, be;
  bit [29:0] k;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input bit [29:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference model of acceptance rules plus bridge responder, evaluated once per cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_cpu.delete();
      exp_bus.delete();
      ref_mem = bus_mem;
      m_out = 0; ld_busy = 0; st_pend = 0; acc_now = 0;
      busy = 0; snap_valid = 0; wr_cnt = 0; dly = 0; ld_exp_cyc = -1;
      mem_bus.addr_ok = 1'b0;
      mem_bus.data_ok = 1'b0;
      mem_bus.rdata   = 32'd0;
    end else begin
      acc_now = 0;
      if (cpu_bus.req) begin
        if (cpu_bus.wr) exp_ok = (m_out < DEPTH) && !ld_busy;
        else            exp_ok = (m_out == 0) && !ld_busy && !st_pend;
        chk(cpu_bus.wr ? "store_addr_ok" : "load_addr_ok", cpu_bus.addr_ok, exp_ok);
        acc_now = cpu_bus.addr_ok;
      end
      st_pend = 0;
      if (acc_now) begin
        k = cpu_bus.addr[31:2];
        be.wr = cpu_bus.wr; be.size = cpu_bus.size; be.addr = cpu_bus.addr;
        if (cpu_bus.wr) begin
          be.wstrb = cpu_bus.wstrb; be.wdata = cpu_bus.wdata;
          exp_bus.push_back(be);
          exp_cpu.push_back('{0, cyc + 1, 32'd0});
          ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : init_word(k), cpu_bus.wdata, cpu_bus.wstrb);
          m_out++;
          st_pend = 1;
        end else begin
          be.wstrb = 4'd0; be.wdata = 32'd0;
          exp_bus.push_back(be);
          exp_cpu.push_back('{1, 0, ref_mem.exists(k) ? ref_mem[k] : init_word(k)});
          ld_busy = 1;
        end
      end

      was_busy = busy;
      fired = 0;
      mem_bus.addr_ok = 1'b0;
      mem_bus.data_ok = 1'b0;
      if (busy) begin
        if (stall_dok || dly > 0) begin
          if (!stall_dok) dly--;
        end else begin
          fired = 1;
          busy = 0;
          mem_bus.data_ok = 1'b1;
          k = cur.addr[31:2];
          if (cur.wr) begin
            bus_mem[k] = merge(bus_mem.exists(k) ? bus_mem[k] : init_word(k), cur.wdata, cur.wstrb);
            m_out--;
            wr_cnt++;
          end else begin
            mem_bus.rdata = bus_mem.exists(k) ? bus_mem[k] : init_word(k);
            ld_busy = 0;
            ld_exp_cyc = cyc + 1;
          end
        end
      end
      if (mem_bus.req) begin
        req_now.wr = mem_bus.wr; req_now.size = mem_bus.size; req_now.wstrb = mem_bus.wstrb;
        req_now.addr = mem_bus.addr; req_now.wdata = mem_bus.wdata;
        chk("single_outstanding", was_busy, 0);
        if (snap_valid) begin
          same = (snap.wr === req_now.wr) && (snap.size === req_now.size) && (snap.wstrb === req_now.wstrb)
                 && (snap.addr === req_now.addr) && (snap.wdata === req_now.wdata);
          chk("bus_req_stable", same, 1);
        end else begin
          snap = req_now;
          snap_valid = 1;
        end
        if (!stall_addr && $urandom_range(0, 2) != 0) begin
          mem_bus.addr_ok = 1'b1;
          snap_valid = 0;
          if (exp_bus.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected: got addr 0x%08h expected no request (cycle %0d)", req_now.addr, cyc);
          end else begin
            be = exp_bus.pop_front();
            chk("bus_wr", req_now.wr, be.wr);
            chk("bus_addr", req_now.addr, be.addr);
            chk("bus_size", req_now.size, be.size);
            chk("bus_wstrb", req_now.wstrb, be.wstrb);
            if (be.wr) chk("bus_wdata", req_now.wdata, be.wdata);
          end
          cur = req_now;
          busy = 1;
          dly = req_now.wr ? $urandom_range(0, 3) : $urandom_range(0, 5);
        end
      end
      // Stray data_ok while nothing is outstanding must be ignored by the DUT.
      if (!fired && !was_busy && $urandom_range(0, 9) == 0) begin
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = $urandom;
      end
    end
  end

  cpu_exp_t me;
  always @(negedge clk) begin
    if (resetn && cpu_bus.data_ok) begin
      if (exp_cpu.size() == 0) begin
        checks++; failures++;
        $display("FAIL cpu_data_ok_unexpected: got data_ok=1 expected 0 (cycle %0d)", cyc);
      end else begin
        me = exp_cpu.pop_front();
        if (me.is_ld) begin
          chk("load_data_ok_cycle", cyc, ld_exp_cyc);
          chk("load_rdata", cpu_bus.rdata, me.rdata);
        end else begin
          chk("store_data_ok_cycle", cyc, me.cyc);
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    cpu_bus.req = 1'b1; cpu_bus.wr = wr; cpu_bus.size = sz;
    cpu_bus.wstrb = st; cpu_bus.addr = a; cpu_bus.wdata = d;
    do begin
      @(posedge clk);
      t++;
    end while (!acc_now && t < 300);
    if (!acc_now) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no addr_ok expected acceptance of 0x%08h", a);
    end
    #1;
    cpu_bus.req = 1'b0;
  endtask

  task automatic rand_op(input bit allow_load);
    logic [31:0] a;
    a = 32'h8000_0000 + ($urandom_range(0, 7) << 2);
    if (allow_load && $urandom_range(0, 9) < 3) issue(0, 2'($urandom), 4'd0, a, 32'd0);
    else issue(1, 2'($urandom), 4'($urandom), a, $urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_bus.size() != 0 || exp_cpu.size() != 0 || busy || !buf_empty) && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain_buf_empty", buf_empty, 1);
    chk("drain_pending", exp_bus.size() + exp_cpu.size(), 0);
  endtask

  int early;
  initial begin
    cpu_bus.req = 1'b0; cpu_bus.wr = 1'b0; cpu_bus.size = 2'd0;
    cpu_bus.wstrb = 4'd0; cpu_bus.addr = 32'd0; cpu_bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_req", mem_bus.req, 0);
    chk("reset_buf_empty", buf_empty, 1);
    chk("reset_data_ok", cpu_bus.data_ok, 0);
    chk("reset_rdata", cpu_bus.rdata, 0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    issue(1, 2'd2, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF);
    drain();

    issue(1, 2'd2, 4'hF, 32'h8000_0020, 32'h1234_5678);
    issue(0, 2'd2, 4'h0, 32'h8000_0020, 32'd0);
    drain();

    stall_addr = 1;
    for (int i = 0; i < 4; i++) issue(1, 2'd2, 4'hF, 32'h8000_0000 + 32'(i * 4), $urandom);
    cpu_bus.req = 1'b1; cpu_bus.wr = 1'b1; cpu_bus.wstrb = 4'hF;
    cpu_bus.addr = 32'h8000_0010; cpu_bus.wdata = 32'hCAFE_0005;
    early = 0;
    repeat (6) begin
      @(posedge clk);
      if (acc_now) early++;
    end
    #1;
    chk("fifth_store_blocked_when_full", early, 0);
    stall_addr = 0;
    issue(1, 2'd2, 4'hF, 32'h8000_0010, 32'hCAFE_0005);
    drain();

    issue(0, 2'd1, 4'h0, 32'h8000_0010, 32'd0);
    issue(1, 2'd2, 4'h3, 32'h8000_0010, 32'h0000_A5A5);
    drain();

    for (int i = 0; i < 150; i++) begin
      rand_op(1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    drain();

    stall_dok = 1;
    for (int i = 0; i < 3; i++) rand_op(0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_buf_empty", buf_empty, 0);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_reset_mem_req", mem_bus.req, 0);
    chk("async_reset_buf_empty", buf_empty, 1);
    chk("async_reset_data_ok", cpu_bus.data_ok, 0);
    stall_dok = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(1, 2'd2, 4'hF, 32'h8000_0008, 32'h5555_AAAA);
    drain();
    chk("post_reset_single_write", wr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
